// File: rtl/ntt_bram_pkg.sv
// Shared types and constants for the NTT coefficient BRAM arbiter.
package ntt_bram_pkg;
  localparam int DATA_W      = 64;
  localparam int IDX_W       = 8;
  localparam int ADDR_SHIFT  = 2;
  localparam int BRAM_ADDR_W = IDX_W + ADDR_SHIFT;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/ntt_bram_arbiter_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, requester id} alongside the BRAM read
// so returning data can be steered to the requester that issued it.
module rd_tag_pipe
  import ntt_bram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk_sys,
  input  logic    rst_b,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_bram_arbiter.sv
// Round-robin burst arbiter sharing one NTT coefficient BRAM port between the
// NTT load/store sequencer (requester 0) and a host/next-stage engine (requester 1).
//
// state    | meaning
// ST_IDLE  | no owner; pick the next owner among valid requesters
// ST_BURST | owner holds the port; one beat accepted per valid cycle
module ntt_bram_arbiter
  import ntt_bram_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 64
) (
  input  logic                   clk_sys,
  input  logic                   rst_b,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0]             req_last,
  input  logic [IDX_W-1:0]       req_idx0,
  input  logic [IDX_W-1:0]       req_idx1,
  input  logic [DATA_W-1:0]      req_wdata0,
  input  logic [DATA_W-1:0]      req_wdata1,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             grant,
  output logic                   burst_trunc,
  output logic [BRAM_ADDR_W-1:0] BRAM_addr_0,
  output logic [DATA_W-1:0]      BRAM_din_0,
  input  logic [DATA_W-1:0]      BRAM_dout_0,
  output logic                   BRAM_en_0,
  output logic                   BRAM_we_0,
  output logic                   BRAM_rst_0,
  output logic                   BRAM_clk_0
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  req_id_t           served_q, served_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trunc_q, trunc_d;
  req_id_t           winner;

  logic                   en_q, we_q;
  logic [BRAM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      din_q;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_q;

  req_id_t           owner;
  logic              accept;
  logic              acc_we, acc_last;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  rd_tag_t           tag_in, tag_out;

  assign owner     = grant_q[1];
  assign accept    = (state_q == ST_BURST) && ((req_valid & grant_q) != 2'b00);
  assign acc_we    = req_we[owner];
  assign acc_last  = req_last[owner];
  assign acc_idx   = owner ? req_idx1 : req_idx0;
  assign acc_wdata = owner ? req_wdata1 : req_wdata0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    served_d  = served_q;
    cnt_d     = cnt_q;
    trunc_d   = 1'b0;
    winner    = 1'b0;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          // on a tie the requester not served last wins
          winner  = (req_valid == 2'b11) ? ~served_q : req_valid[1];
          grant_d = winner ? 2'b10 : 2'b01;
          cnt_d   = CNT_LOAD;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        req_ready = grant_q;
        if (accept) begin
          if (acc_last || (cnt_q == '0)) begin
            state_d  = ST_IDLE;
            grant_d  = 2'b00;
            served_d = owner;
            trunc_d  = !acc_last;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      served_q <= 1'b0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      served_q <= served_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      en_q <= accept;
      we_q <= accept && acc_we;
      if (accept) begin
        addr_q <= BRAM_ADDR_W'(acc_idx) << ADDR_SHIFT;
        din_q  <= acc_wdata;
      end
    end
  end

  // writes push an invalid tag so the pipe stays aligned with BRAM latency
  assign tag_in.valid = accept && !acc_we;
  assign tag_in.id    = owner;

  rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk_sys (clk_sys),
    .rst_b   (rst_b),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  assign rsp_valid_d = tag_out.valid ? (2'b01 << tag_out.id) : 2'b00;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tag_out.valid) rsp_rdata_q <= BRAM_dout_0;
    end
  end

  assign grant       = grant_q;
  assign burst_trunc = trunc_q;
  assign BRAM_en_0   = en_q;
  assign BRAM_we_0   = we_q;
  assign BRAM_addr_0 = addr_q;
  assign BRAM_din_0  = din_q;
  assign BRAM_rst_0  = 1'b0;
  assign BRAM_clk_0  = clk_sys;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Directed bench for ntt_bram_arbiter with a behavioural 2-cycle-latency BRAM.
module tb_ntt_bram_arbiter;
  import ntt_bram_pkg::*;

  logic                   clk_sys = 1'b0;
  logic                   rst_b   = 1'b1;
  logic [1:0]             req_valid, req_ready, req_we, req_last;
  logic [IDX_W-1:0]       req_idx0, req_idx1;
  logic [DATA_W-1:0]      req_wdata0, req_wdata1;
  logic [1:0]             rsp_valid, grant;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   burst_trunc;
  logic [BRAM_ADDR_W-1:0] BRAM_addr_0;
  logic [DATA_W-1:0]      BRAM_din_0, BRAM_dout_0;
  logic                   BRAM_en_0, BRAM_we_0, BRAM_rst_0, BRAM_clk_0;

  int total = 0;
  int bad   = 0;
  int nb0, nb1;
  logic [1:0] acc;

  logic [1:0]        exp_gnt4 [16] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2,
                                       2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0]        exp_rsp4 [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0,
                                       2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1};
  logic [DATA_W-1:0] exp_dat4 [16] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'hA2, 64'hA3, 64'h0,
                                       64'hA0, 64'hA1, 64'h0, 64'hA2, 64'hA3, 64'h0, 64'hA0, 64'hA1};

  always #5 clk_sys = ~clk_sys;

  // BRAM model: registered command in, data out RD_LAT=2 cycles later
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd_s1;
  always @(posedge BRAM_clk_0) begin
    if (BRAM_en_0 && BRAM_we_0) mem[BRAM_addr_0[9:2]] <= BRAM_din_0;
    rd_s1       <= mem[BRAM_addr_0[9:2]];
    BRAM_dout_0 <= rd_s1;
  end

  ntt_bram_arbiter #(.RD_LAT(2), .MAX_BURST(64)) dut (
    .clk_sys     (clk_sys),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_last    (req_last),
    .req_idx0    (req_idx0),
    .req_idx1    (req_idx1),
    .req_wdata0  (req_wdata0),
    .req_wdata1  (req_wdata1),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .grant       (grant),
    .burst_trunc (burst_trunc),
    .BRAM_addr_0 (BRAM_addr_0),
    .BRAM_din_0  (BRAM_din_0),
    .BRAM_dout_0 (BRAM_dout_0),
    .BRAM_en_0   (BRAM_en_0),
    .BRAM_we_0   (BRAM_we_0),
    .BRAM_rst_0  (BRAM_rst_0),
    .BRAM_clk_0  (BRAM_clk_0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_trunc"}, burst_trunc, 0);
    chk({tag, "_en"}, BRAM_en_0, 0);
    chk({tag, "_we"}, BRAM_we_0, 0);
    chk({tag, "_addr"}, BRAM_addr_0, 0);
    chk({tag, "_din"}, BRAM_din_0, 0);
    chk({tag, "_bram_rst"}, BRAM_rst_0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_we = '0; req_last = '0;
    req_idx0 = '0; req_idx1 = '0; req_wdata0 = '0; req_wdata1 = '0;

    // power-on reset
    #2 rst_b = 1'b0;
    @(negedge clk_sys);
    chk_all_zero("por");
    next_cycle();
    #2 rst_b = 1'b1;
    next_cycle();

    // requester 0 writes idx 0..3 with 0xA0..0xA3
    req_valid = 2'b01; req_we = 2'b01; req_idx0 = 8'd0; req_wdata0 = 64'hA0;
    @(negedge clk_sys);
    chk("wr_idle_grant", grant, 0);
    chk("wr_idle_ready", req_ready, 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      req_idx0 = 8'(i); req_wdata0 = 64'hA0 + 64'(i); req_last = (i == 3) ? 2'b01 : 2'b00;
      @(negedge clk_sys);
      chk("wr_grant", grant, 2'b01);
      chk("wr_ready", req_ready, 2'b01);
      if (i > 0) begin
        chk("wr_addr", BRAM_addr_0, 64'((i - 1) * 4));
        chk("wr_din", BRAM_din_0, 64'hA0 + 64'(i - 1));
        chk("wr_we", BRAM_we_0, 1);
      end
      next_cycle();
    end
    req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk_sys);
    chk("wr_last_addr", BRAM_addr_0, 12);
    chk("wr_last_din", BRAM_din_0, 64'hA3);
    chk("wr_last_en", BRAM_en_0, 1);
    chk("wr_end_grant", grant, 0);
    next_cycle();
    @(negedge clk_sys);
    chk("wr_idle_en", BRAM_en_0, 0);
    next_cycle();

    // requester 0 reads idx 0..3
    req_valid = 2'b01; req_we = 2'b00; req_idx0 = 8'd0;
    @(negedge clk_sys);
    chk("rd_idle_grant", grant, 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      req_idx0 = 8'(i); req_last = (i == 3) ? 2'b01 : 2'b00;
      @(negedge clk_sys);
      chk("rd_ready", req_ready, 2'b01);
      chk("rd_no_rsp_yet", rsp_valid, 0);
      next_cycle();
    end
    req_valid = 2'b00; req_last = 2'b00;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_sys);
      chk("rd_rsp_valid", rsp_valid, 2'b01);
      chk("rd_rsp_data", rsp_rdata, 64'hA0 + 64'(j));
      next_cycle();
    end
    @(negedge clk_sys);
    chk("rd_rsp_done", rsp_valid, 0);
    next_cycle();

    // requester 1 reads idx 0,1, then reset lands while both reads are in flight
    req_valid = 2'b10; req_we = 2'b00; req_idx1 = 8'd0;
    next_cycle();
    req_idx1 = 8'd0; req_last = 2'b00;
    @(negedge clk_sys);
    chk("rst_pre_grant", grant, 2'b10);
    next_cycle();
    req_idx1 = 8'd1; req_last = 2'b10;
    next_cycle();
    req_valid = 2'b00; req_last = 2'b00;
    #2 rst_b = 1'b0;
    @(negedge clk_sys);
    chk_all_zero("rst_mid");
    next_cycle();
    next_cycle();
    #2 rst_b = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_sys);
      chk("rst_no_rsp", rsp_valid, 0);
      next_cycle();
    end

    // both requesters stream 2-beat reads: req0 idx 0,1 and req1 idx 2,3
    nb0 = 0; nb1 = 0;
    for (int t = 0; t < 16; t++) begin
      req_valid  = (t < 12) ? 2'b11 : 2'b00;
      req_we     = 2'b00;
      req_idx0   = 8'(nb0 % 2);
      req_idx1   = 8'(2 + nb1 % 2);
      req_last   = {(nb1 % 2) == 1, (nb0 % 2) == 1};
      @(negedge clk_sys);
      chk("rr_grant", grant, exp_gnt4[t]);
      chk("rr_rsp_valid", rsp_valid, exp_rsp4[t]);
      if (exp_rsp4[t] != 2'b00) chk("rr_rsp_data", rsp_rdata, exp_dat4[t]);
      acc = req_valid & req_ready;
      next_cycle();
      if (acc[0]) nb0++;
      if (acc[1]) nb1++;
    end

    // requester 1 sends 70 write beats (last only on the 70th); requester 0 waits
    nb0 = 0; nb1 = 0;
    for (int t = 0; t < 76; t++) begin
      req_valid  = {nb1 < 70, nb0 < 1};
      req_we     = 2'b11;
      req_idx0   = 8'd200; req_wdata0 = 64'hBEEF;
      req_idx1   = 8'(nb1); req_wdata1 = 64'h100 + 64'(nb1);
      req_last   = {nb1 == 69, 1'b1};
      @(negedge clk_sys);
      if (t == 64) begin chk("tr_grant64", grant, 2'b10); chk("tr_pulse64", burst_trunc, 0); end
      if (t == 65) begin chk("tr_pulse", burst_trunc, 1); chk("tr_grant65", grant, 0); end
      if (t == 66) begin chk("tr_pulse66", burst_trunc, 0); chk("tr_grant66", grant, 2'b01); end
      if (t == 67) chk("tr_grant67", grant, 0);
      if (t == 68) chk("tr_grant68", grant, 2'b10);
      if (t == 69) begin
        chk("tr_addr65", BRAM_addr_0, 256);
        chk("tr_din65", BRAM_din_0, 64'h140);
        chk("tr_we65", BRAM_we_0, 1);
      end
      if (t == 73) chk("tr_grant73", grant, 2'b10);
      if (t == 74) begin chk("tr_grant74", grant, 0); chk("tr_pulse74", burst_trunc, 0); end
      if (t == 75) chk("tr_grant75", grant, 0);
      acc = req_valid & req_ready;
      next_cycle();
      if (acc[0]) nb0++;
      if (acc[1]) nb1++;
    end

    // requester 0 stalls 3 cycles mid-burst; requester 1 must wait, then read idx 10
    nb0 = 0; nb1 = 0;
    for (int t = 0; t < 16; t++) begin
      req_valid  = {nb1 < 1, (nb0 < 4) && !(t >= 3 && t <= 5)};
      req_we     = 2'b01;
      req_idx0   = 8'(10 + nb0); req_wdata0 = 64'hC0 + 64'(nb0);
      req_idx1   = 8'd10;
      req_last   = {1'b1, nb0 == 3};
      @(negedge clk_sys);
      if (t == 1) chk("st_grant1", grant, 2'b01);
      if (t == 3) chk("st_en3", BRAM_en_0, 1);
      if (t >= 3 && t <= 5) begin
        chk("st_grant_hold", grant, 2'b01);
        chk("st_ready_hold", req_ready, 2'b01);
      end
      if (t >= 4 && t <= 6) chk("st_en_gap", BRAM_en_0, 0);
      if (t == 7) begin
        chk("st_en7", BRAM_en_0, 1);
        chk("st_addr7", BRAM_addr_0, 48);
        chk("st_din7", BRAM_din_0, 64'hC2);
      end
      if (t == 8) begin chk("st_grant8", grant, 0); chk("st_addr8", BRAM_addr_0, 52); end
      if (t == 9) chk("st_grant9", grant, 2'b10);
      if (t == 12) chk("st_rsp12", rsp_valid, 0);
      if (t == 13) begin
        chk("st_rsp13", rsp_valid, 2'b10);
        chk("st_rdata13", rsp_rdata, 64'hC0);
      end
      acc = req_valid & req_ready;
      next_cycle();
      if (acc[0]) nb0++;
      if (acc[1]) nb1++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
